// File: rtl/ifid_stage.sv
// IF/ID pipeline register with a one-entry hold buffer for the fetch response
// that returns while decode is stalled.
module ifid_stage #(
  parameter logic [4:0]  EXC_NONE = 5'h10,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  input  logic [31:0] pc_plus_4,
  input  logic [4:0]  if_exccode_i,
  input  logic [31:0] if_badvaddr_i,
  input  logic [31:0] inst_rdata,
  input  logic [3:0]  stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus_4,
  output logic [31:0] id_inst,
  output logic [4:0]  id_exccode,
  output logic [31:0] id_badvaddr,
  output logic        buf_ovf
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } pkt_t;

  logic        trk_valid, trk_mem;
  logic [31:0] trk_pc, trk_pc4, trk_badvaddr;
  logic [4:0]  trk_exccode;
  logic        hold_valid, out_valid;
  pkt_t        hold, out, resp, bubble;
  logic        issue;

  // Misaligned fetches make no memory access but still need a packet downstream.
  assign issue  = !flush && !stall[1] && (ice || (if_exccode_i != EXC_NONE));
  assign resp   = '{pc: trk_pc, pc4: trk_pc4, inst: (trk_mem ? inst_rdata : NOP_INST),
                    exccode: trk_exccode, badvaddr: trk_badvaddr};
  assign bubble = '{pc: 32'h0, pc4: 32'h0, inst: NOP_INST, exccode: EXC_NONE, badvaddr: 32'h0};

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      trk_valid    <= 1'b0;
      trk_mem      <= 1'b0;
      trk_pc       <= 32'h0;
      trk_pc4      <= 32'h0;
      trk_exccode  <= EXC_NONE;
      trk_badvaddr <= 32'h0;
    end else begin
      trk_valid <= issue;
      if (issue) begin
        trk_mem      <= ice;
        trk_pc       <= iaddr;
        trk_pc4      <= pc_plus_4;
        trk_exccode  <= if_exccode_i;
        trk_badvaddr <= if_badvaddr_i;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush) begin
      out_valid  <= 1'b0;
      out        <= bubble;
      hold_valid <= 1'b0;
      hold       <= bubble;
    end else if (!stall[2]) begin
      if (hold_valid) begin
        // Buffered word is older than the live response, so it goes first.
        out_valid  <= 1'b1;
        out        <= hold;
        hold_valid <= trk_valid;
        if (trk_valid) hold <= resp;
      end else if (trk_valid) begin
        out_valid <= 1'b1;
        out       <= resp;
      end else begin
        out_valid <= 1'b0;
        out       <= bubble;
      end
    end else if (trk_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold       <= resp;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst)
      buf_ovf <= 1'b0;
    else if (!flush && stall[2] && trk_valid && hold_valid)
      buf_ovf <= 1'b1;
  end

  assign id_valid     = out_valid;
  assign id_pc        = out.pc;
  assign id_pc_plus_4 = out.pc4;
  assign id_inst      = out.inst;
  assign id_exccode   = out.exccode;
  assign id_badvaddr  = out.badvaddr;
endmodule

// File: tb/tb_ifid_stage.sv
// Bench for ifid_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifid_stage;
  localparam logic [4:0]  EXC_NONE = 5'h10;
  localparam logic [31:0] NOP      = 32'h0;

  logic        clk = 1'b0;
  logic        rst, ice, flush;
  logic [31:0] iaddr, pc4, badv, rdata;
  logic [4:0]  exc;
  logic [3:0]  stall;
  logic        id_valid, buf_ovf;
  logic [31:0] id_pc, id_pc_plus_4, id_inst, id_badvaddr;
  logic [4:0]  id_exccode;

  ifid_stage #(.EXC_NONE(EXC_NONE), .NOP_INST(NOP)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .ice(ice), .iaddr(iaddr), .pc_plus_4(pc4),
    .if_exccode_i(exc), .if_badvaddr_i(badv), .inst_rdata(rdata), .stall(stall),
    .flush(flush), .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
    .id_inst(id_inst), .id_exccode(id_exccode), .id_badvaddr(id_badvaddr),
    .buf_ovf(buf_ovf));

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          mem;
    logic [31:0] pc, pc4, inst, bad;
    logic [4:0]  exc;
  } pkt_t;

  pkt_t q[$];
  pkt_t m_out, m_pend;
  bit   m_ovf;
  int   n_chk = 0, n_fail = 0;

  function automatic pkt_t bubble();
    pkt_t p;
    p.v = 0; p.mem = 0; p.pc = 0; p.pc4 = 0; p.inst = NOP; p.bad = 0; p.exc = EXC_NONE;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every fetch/response is a packet in an ordered queue; decode takes the head
  // each unstalled cycle, and a stalled decode can absorb only one packet.
  task automatic model_edge();
    pkt_t r;
    if (rst) begin
      q.delete(); m_out = bubble(); m_pend = bubble(); m_ovf = 0;
    end else if (flush) begin
      q.delete(); m_out = bubble(); m_pend = bubble();
    end else begin
      if (m_pend.v) begin
        r = m_pend;
        r.inst = m_pend.mem ? rdata : NOP;
        if (!stall[2] || q.size() == 0) q.push_back(r);
        else m_ovf = 1;
      end
      if (!stall[2]) m_out = (q.size() != 0) ? q.pop_front() : bubble();
      m_pend = bubble();
      if (!stall[1] && (ice || exc != EXC_NONE)) begin
        m_pend.v = 1; m_pend.mem = ice; m_pend.pc = iaddr; m_pend.pc4 = pc4;
        m_pend.exc = exc; m_pend.bad = badv;
      end
    end
  endtask

  task automatic compare();
    chk("valid", {31'h0, id_valid}, {31'h0, m_out.v});
    chk("pc", id_pc, m_out.pc);
    chk("pc4", id_pc_plus_4, m_out.pc4);
    chk("inst", id_inst, m_out.inst);
    chk("exccode", {27'h0, id_exccode}, {27'h0, m_out.exc});
    chk("badvaddr", id_badvaddr, m_out.bad);
    chk("buf_ovf", {31'h0, buf_ovf}, {31'h0, m_ovf});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    rst = 0; ice = 0; flush = 0; stall = 4'b0; exc = EXC_NONE;
    iaddr = 0; pc4 = 4; badv = 0; rdata = 32'hFFFF_FFFF;
  endtask

  task automatic fetch(input logic [31:0] a);
    ice = 1; iaddr = a; pc4 = a + 4; exc = EXC_NONE; badv = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    m_out = bubble(); m_pend = bubble(); m_ovf = 0;
    idle();
    do_reset();
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_exc", {27'h0, id_exccode}, 32'h10);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_ovf", {31'h0, buf_ovf}, 32'h0);

    // Streaming
    fetch(32'h00); tick();
    fetch(32'h04); rdata = 32'h11; tick();
    chk("s1_pc", id_pc, 32'h00); chk("s1_inst", id_inst, 32'h11);
    chk("s1_valid", {31'h0, id_valid}, 32'h1);
    fetch(32'h08); rdata = 32'h22; tick();
    chk("s2_pc", id_pc, 32'h04); chk("s2_inst", id_inst, 32'h22);
    ice = 0; rdata = 32'h33; tick();
    chk("s3_pc", id_pc, 32'h08); chk("s3_inst", id_inst, 32'h33);
    chk("s3_pc4", id_pc_plus_4, 32'h0C);

    // Stall with buffering: 0x04 returns during the stall and is held
    idle(); do_reset();
    fetch(32'h00); tick();
    fetch(32'h04); rdata = 32'h11; tick();
    fetch(32'h08); stall = 4'b0110; rdata = 32'h22; tick();
    chk("st2_pc", id_pc, 32'h00);
    rdata = 32'hDEAD; tick(); tick();
    chk("st4_pc", id_pc, 32'h00); chk("st4_inst", id_inst, 32'h11);
    stall = 4'b0; tick();
    chk("st5_pc", id_pc, 32'h04); chk("st5_inst", id_inst, 32'h22);
    fetch(32'h0C); rdata = 32'h33; tick();
    chk("st6_pc", id_pc, 32'h08); chk("st6_inst", id_inst, 32'h33);
    chk("st6_ovf", {31'h0, buf_ovf}, 32'h0);

    // Misaligned fetch
    idle(); iaddr = 32'h06; pc4 = 32'h0A; exc = 5'h04; badv = 32'h06; tick();
    idle(); rdata = 32'h5555; tick();
    chk("mis_exc", {27'h0, id_exccode}, 32'h04);
    chk("mis_bad", id_badvaddr, 32'h06);
    chk("mis_inst", id_inst, 32'h0);
    chk("mis_valid", {31'h0, id_valid}, 32'h1);

    // Flush during stall with hold occupied
    idle(); do_reset();
    fetch(32'h100); tick();
    fetch(32'h104); stall = 4'b0110; rdata = 32'hAAAA; tick();
    flush = 1; tick();
    chk("fl_valid", {31'h0, id_valid}, 32'h0);
    idle(); fetch(32'h180); tick();
    chk("fl_gap", {31'h0, id_valid}, 32'h0);
    idle(); rdata = 32'hBBBB; tick();
    chk("fl_pc", id_pc, 32'h180); chk("fl_inst", id_inst, 32'hBBBB);

    // Reset mid-stream
    fetch(32'h200); tick();
    rst = 1; ice = 0; rdata = 32'hDEAD_BEEF; tick();
    chk("rm_valid", {31'h0, id_valid}, 32'h0);
    chk("rm_exc", {27'h0, id_exccode}, 32'h10);
    rst = 0; rdata = 32'hDEAD_BEEF; tick();
    chk("rm_after", {31'h0, id_valid}, 32'h0);

    // Overflow: hold filled, then an extra response while still stalled
    idle();
    fetch(32'h40); tick();
    fetch(32'h44); stall = 4'b0100; rdata = 32'h40; tick();
    ice = 0; rdata = 32'h44; tick();
    chk("ovf_set", {31'h0, buf_ovf}, 32'h1);
    idle(); tick(); flush = 1; tick(); flush = 0; tick();
    chk("ovf_sticky", {31'h0, buf_ovf}, 32'h1);
    do_reset();
    chk("ovf_clr", {31'h0, buf_ovf}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      idle();
      ice = ($urandom_range(0, 3) != 0);
      iaddr = {$urandom_range(0, 32'h3FFF), 2'b00};
      pc4 = iaddr + 4;
      if ($urandom_range(0, 9) == 0) begin
        exc = 5'($urandom_range(0, 15));
        badv = iaddr | 32'h2;
      end
      rdata = $urandom;
      r = $urandom_range(0, 9);
      stall = (r < 3) ? 4'b0110 : (r == 3) ? 4'b0100 :
              (r == 4) ? 4'($urandom_range(0, 15)) : 4'b0000;
      flush = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifid_stage.md
# ifid_stage

Pipeline register and fetch-return buffer between the instruction-fetch stage and the decode stage. It tracks each fetch issued in one cycle and pairs the instruction word returned by the synchronous instruction memory in the next cycle with that fetch's PC and exception information. It holds one returned word when decode is stalled, so no fetched instruction is lost. It presents a registered, valid-qualified instruction packet to decode and squashes everything in flight on a pipeline flush.

## Interface
Parameters:
- `EXC_NONE`, default 5'h10: exception code meaning "no exception".
- `NOP_INST`, default 32'h0000_0000: instruction word substituted when no memory access was made.

Ports:
- `cpu_clk_50M`  in  1  sole clock; all state updates on its rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `ice`  in  1  instruction memory access issued this cycle.
- `iaddr`  in  32  PC of the fetch issued this cycle.
- `pc_plus_4`  in  32  iaddr + 4 from fetch.
- `if_exccode_i`  in  5  fetch exception code for this cycle's PC.
- `if_badvaddr_i`  in  32  faulting address for this cycle's PC.
- `inst_rdata`  in  32  memory read data, valid exactly one cycle after `ice`=1.
- `stall`  in  4  bit0 PC hold, bit1 IF hold, bit2 ID hold, bit3 EX hold.
- `flush`  in  1  squash all in-flight instructions.
- `id_valid`  out  1  decode packet is a real instruction.
- `id_pc`  out  32  PC of the packet.
- `id_pc_plus_4`  out  32  PC + 4 of the packet.
- `id_inst`  out  32  instruction word.
- `id_exccode`  out  5  exception code carried to decode.
- `id_badvaddr`  out  32  bad virtual address carried to decode.
- `buf_ovf`  out  1  sticky error: a response arrived while the hold buffer was full.

## Operation
- **Tracker** (`trk_*`): on each edge, `trk_valid` <= issue, where issue = !flush & !stall[1] & (ice | if_exccode_i != EXC_NONE). When issue=1 the tracker captures iaddr, pc_plus_4, exccode, badvaddr and `trk_mem`=ice.
- **Response:** when `trk_valid`=1, a response exists this cycle. Its word is `inst_rdata` if `trk_mem`=1, else NOP_INST. Its exccode and badvaddr are taken from the tracker.
- **Hold buffer:** one entry (`hold_valid` plus packet).
- **Output register update when stall[2]=0**, in priority order:
  - hold_valid: output <= hold. If a response is also present, hold <= response; else hold_valid <= 0.
  - else if a response is present: output <= response.
  - else: bubble. id_valid=0, id_inst=NOP_INST, id_exccode=EXC_NONE, id_pc, id_pc_plus_4 and id_badvaddr = 0.
- **When stall[2]=1:** the output register holds. A present response goes to hold. If hold_valid is already 1, the response is dropped and `buf_ovf` <= 1.
- **Flush:** on the next edge, tracker, hold and output all clear to bubble. Flush overrides stall and any present response. A response arriving in the flush cycle is discarded.
- **Reset:** all outputs, `trk_valid`, `hold_valid` and `buf_ovf` become 0 (id_exccode=EXC_NONE, id_inst=NOP_INST). Reset overrides flush. A fetch in flight at reset is discarded.
- `buf_ovf` clears only on reset.
- Packet fields travel together; no field mixes data from two fetches.

## Timing
- Latency: `ice`=1 in cycle t → `inst_rdata` in t+1 → id_* valid from edge at end of t+1 (2 cycles issue-to-decode).
- Misaligned fetch (ice=0, exccode≠EXC_NONE) has the same 2-cycle latency, with id_inst=NOP_INST.
- Stall onset: stall[1] and stall[2] rise together. The fetch issued in the cycle before onset is captured into hold.
- On stall release, hold is presented on the first edge with stall[2]=0, then normal flow resumes. There are no gaps and no duplicates.
- Throughput: one packet per cycle with no stall.

## Test plan
- **Streaming:** ice=1 with iaddr 0x00,0x04,0x08 in cycles 0-2 and rdata 0x11,0x22,0x33 in cycles 1-3 → id_pc/id_inst = 0x00/0x11 after cycle 1, 0x04/0x22 after cycle 2, 0x08/0x33 after cycle 3, all with id_valid=1.
- **Stall with buffering:** stall[2:1]=11 for cycles 2-4 while 0x04 is in flight → output holds 0x00 through cycle 4; 0x04 is presented after cycle 5, then 0x08. buf_ovf stays 0.
- **Misaligned fetch:** iaddr=0x06, ice=0, exccode=5'h04, badvaddr=0x06 → two cycles later id_exccode=5'h04, id_badvaddr=0x06, id_inst=NOP_INST, id_valid=1.
- **Flush during stall:** hold_valid=1, stall[2]=1, flush=1 → next cycle id_valid=0, hold is empty, and the following fetch from the handler address appears 2 cycles after its ice.
- **Reset mid-stream:** cpu_rst=1 while a fetch is in flight → id_valid=0, id_exccode=EXC_NONE, buf_ovf=0. The in-flight rdata never appears.
- **Overflow:** force hold full with stall[2]=1 plus an extra response → buf_ovf=1 and it stays 1 until reset.
